countdown_ctrl: RTL and testbench

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

---
 rtl/timer_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 33 +++
 rtl/countdown_ctrl.sv | 112 +++++++++++
 tb/tb_countdown_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and tick-rate constants.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Production rate is 1 s per tick at 50 MHz; the simulation value keeps benches short.
  localparam int TICK_DIV_DEFAULT = 50_000_000;
  localparam int TICK_DIV_SIM     = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clk divider for the countdown timer. The tick output is a combinational
// terminal-count strobe so the owning FSM can register its own tick in the same edge as the wrap.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int                PSC_W = $clog2(TICK_DIV);
  localparam logic [PSC_W-1:0]  LAST  = PSC_W'(TICK_DIV - 1);

  logic [PSC_W-1:0] count_reg;

  assign tick = en && (count_reg == LAST);

  // Holding en low freezes the count, which is what lets PAUSE resume mid-period.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= tick ? '0 : count_reg + PSC_W'(1);
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer: loads a tick count, decrements it once per prescaler period while running,
// supports pause/resume and abort, and pulses done when the count reaches zero.
module countdown_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             hold,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             paused,
  output logic             tick,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic             tick_reg, tick_next;
  logic             done_reg, done_next;
  logic             psc_en, psc_clr, psc_wrap;

  assign psc_en = (state_reg == RUN);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (psc_en),
    .clr    (psc_clr),
    .tick   (psc_wrap)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      tick_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      tick_reg      <= tick_next;
      done_reg      <= done_next;
    end
  end

  // Command priority is clear, then start, then hold; a wrap in RUN is serviced before hold.
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    tick_next      = 1'b0;
    done_next      = 1'b0;
    psc_clr        = 1'b0;

    if (clear) begin
      state_next     = IDLE;
      remaining_next = '0;
      psc_clr        = 1'b1;
    end else if (start) begin
      psc_clr = 1'b1;
      if (load_val != '0) begin
        state_next     = RUN;
        remaining_next = load_val;
      end else begin
        state_next     = IDLE;
        remaining_next = '0;
        done_next      = 1'b1;
      end
    end else begin
      case (state_reg)
        RUN: begin
          if (psc_wrap) begin
            tick_next = 1'b1;
            // The <= guard keeps remaining from ever wrapping below zero.
            if (remaining_reg <= CNT_W'(1)) begin
              remaining_next = '0;
              done_next      = 1'b1;
              state_next     = IDLE;
            end else begin
              remaining_next = remaining_reg - CNT_W'(1);
              state_next     = hold ? PAUSE : RUN;
            end
          end else if (hold) begin
            state_next = PAUSE;
          end
        end
        PAUSE: begin
          if (!hold) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign remaining = remaining_reg;
  assign busy      = (state_reg == RUN) || (state_reg == PAUSE);
  assign paused    = (state_reg == PAUSE);
  assign tick      = tick_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed self-checking bench for countdown_ctrl at TICK_DIV=4, CNT_W=8.
module tb_countdown_ctrl;
  import timer_pkg::*;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] load_val = '0;
  logic [CW-1:0] remaining;
  logic          busy, paused, tick, done;

  int tests_run = 0;
  int tests_failed = 0;

  countdown_ctrl #(
    .TICK_DIV(TICK_DIV_SIM),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .hold     (hold),
    .clear    (clear),
    .load_val (load_val),
    .remaining(remaining),
    .busy     (busy),
    .paused   (paused),
    .tick     (tick),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    start = 1'b0;
    hold  = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    tests_run++;
    if ({busy, paused, tick, done, remaining} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_hold got=%b exp=%b", {busy, paused, tick, done, remaining}, 12'h000);
    end
    reset_n = 1'b1;
    step();
    tests_run++;
    if ({busy, paused, tick, done, remaining} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_release got=%b exp=%b", {busy, paused, tick, done, remaining}, 12'h000);
    end
    start = 1'b1;
    load_val = 8'd3;
    step();
    start = 1'b0;
    tests_run++;
    if ({busy, paused, tick, done, remaining} !== {4'b1000, 8'd3}) begin
      tests_failed++;
      $display("FAIL reset_prerun got=%b exp=%b", {busy, paused, tick, done, remaining}, {4'b1000, 8'd3});
    end
    step();
    step();
    reset_n = 1'b0;
    step();
    tests_run++;
    if ({busy, paused, tick, done, remaining} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_midrun got=%b exp=%b", {busy, paused, tick, done, remaining}, 12'h000);
    end
    reset_n = 1'b1;
    step();
    tests_run++;
    if ({busy, paused, tick, done, remaining} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_after got=%b exp=%b", {busy, paused, tick, done, remaining}, 12'h000);
    end
    $display("[TB] test_reset complete");
  endtask

  task automatic test_countdown();
    logic eb, et, ed;
    logic [CW-1:0] er;
    go_idle();
    for (int c = 0; c < 15; c++) begin
      start = (c == 0);
      load_val = 8'd3;
      step();
      eb = (c + 1 <= 12);
      et = (c + 1 == 5) || (c + 1 == 9) || (c + 1 == 13);
      ed = (c + 1 == 13);
      er = (c + 1 <= 4) ? 8'd3 : (c + 1 <= 8) ? 8'd2 : (c + 1 <= 12) ? 8'd1 : 8'd0;
      tests_run++;
      if ({busy, paused, tick, done, remaining} !== {eb, 1'b0, et, ed, er}) begin
        tests_failed++;
        $display("FAIL countdown cyc=%0d got=%b exp=%b", c + 1,
                 {busy, paused, tick, done, remaining}, {eb, 1'b0, et, ed, er});
      end
    end
    start = 1'b0;
    $display("[TB] test_countdown complete");
  endtask

  task automatic test_hold();
    logic eb, ep, et, ed;
    logic [CW-1:0] er;
    go_idle();
    for (int c = 0; c < 16; c++) begin
      start = (c == 0);
      load_val = 8'd2;
      hold = (c >= 3) && (c <= 7);
      step();
      eb = (c + 1 <= 13);
      ep = (c + 1 >= 4) && (c + 1 <= 8);
      et = (c + 1 == 10) || (c + 1 == 14);
      ed = (c + 1 == 14);
      er = (c + 1 <= 9) ? 8'd2 : (c + 1 <= 13) ? 8'd1 : 8'd0;
      tests_run++;
      if ({busy, paused, tick, done, remaining} !== {eb, ep, et, ed, er}) begin
        tests_failed++;
        $display("FAIL hold cyc=%0d got=%b exp=%b", c + 1,
                 {busy, paused, tick, done, remaining}, {eb, ep, et, ed, er});
      end
    end
    start = 1'b0;
    hold = 1'b0;
    $display("[TB] test_hold complete");
  endtask

  task automatic test_zero_load();
    logic ed;
    go_idle();
    for (int c = 0; c < 6; c++) begin
      start = (c == 0);
      load_val = 8'd0;
      hold = 1'b1;
      step();
      ed = (c + 1 == 1);
      tests_run++;
      if ({busy, paused, tick, done, remaining} !== {3'b000, ed, 8'd0}) begin
        tests_failed++;
        $display("FAIL zero_load cyc=%0d got=%b exp=%b", c + 1,
                 {busy, paused, tick, done, remaining}, {3'b000, ed, 8'd0});
      end
    end
    start = 1'b0;
    hold = 1'b0;
    $display("[TB] test_zero_load complete");
  endtask

  task automatic test_clear();
    logic eb, et, ed;
    logic [CW-1:0] er;
    go_idle();
    for (int c = 0; c < 17; c++) begin
      start = (c == 0) || (c == 7);
      load_val = (c == 0) ? 8'd5 : 8'd2;
      clear = (c == 6);
      step();
      eb = (c + 1 <= 6) || ((c + 1 >= 8) && (c + 1 <= 15));
      et = (c + 1 == 5) || (c + 1 == 12) || (c + 1 == 16);
      ed = (c + 1 == 16);
      er = (c + 1 <= 4) ? 8'd5 : (c + 1 <= 6) ? 8'd4 : (c + 1 == 7) ? 8'd0 :
           (c + 1 <= 11) ? 8'd2 : (c + 1 <= 15) ? 8'd1 : 8'd0;
      tests_run++;
      if ({busy, paused, tick, done, remaining} !== {eb, 1'b0, et, ed, er}) begin
        tests_failed++;
        $display("FAIL clear cyc=%0d got=%b exp=%b", c + 1,
                 {busy, paused, tick, done, remaining}, {eb, 1'b0, et, ed, er});
      end
    end
    start = 1'b0;
    clear = 1'b0;
    $display("[TB] test_clear complete");
  endtask

  task automatic test_back_to_back();
    logic et;
    logic [CW-1:0] er;
    go_idle();
    for (int c = 0; c < 10; c++) begin
      start = (c == 0) || (c == 4);
      load_val = (c == 0) ? 8'd1 : 8'd7;
      step();
      et = (c + 1 == 9);
      er = (c + 1 <= 4) ? 8'd1 : (c + 1 <= 8) ? 8'd7 : 8'd6;
      tests_run++;
      if ({busy, paused, tick, done, remaining} !== {1'b1, 1'b0, et, 1'b0, er}) begin
        tests_failed++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c + 1,
                 {busy, paused, tick, done, remaining}, {1'b1, 1'b0, et, 1'b0, er});
      end
    end
    start = 1'b0;
    $display("[TB] test_back_to_back complete");
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_hold();
    test_zero_load();
    test_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
